// File: rtl/wvlt_haar_stage.sv
// First-level Haar analysis: decimates a stream of adjacent-sample pairs by two,
// emitting sum/difference coefficients with frame position and truncation flags.
module wvlt_haar_stage #(
  parameter int pW_IN  = 16,
  parameter int pWORDS = 128,
  parameter int pW_CNT = $clog2(pWORDS/2)
) (
  input  logic                    iclk,
  input  logic                    irst,
  input  logic                    iclk_ena,
  input  logic                    iena,
  input  logic signed [pW_IN-1:0] idat_l,
  input  logic signed [pW_IN-1:0] idat_h,
  output logic                    ovalid,
  output logic signed [pW_IN:0]   oapp,
  output logic signed [pW_IN:0]   odet,
  output logic [pW_CNT-1:0]       ocnt,
  output logic                    osop,
  output logic                    oeop,
  output logic                    oerr
);

  localparam int STAGES = 2;
  localparam logic [pW_CNT-1:0] LAST = pW_CNT'(pWORDS/2 - 1);

  typedef struct packed {
    logic [pW_IN-1:0]  l;
    logic [pW_IN-1:0]  h;
    logic [pW_CNT-1:0] idx;
  } pair_t;

  logic              phase;
  logic [pW_CNT-1:0] idx;
  logic              cap, trunc;
  pair_t             s1;
  logic [STAGES:1]   vld_pipe, err_pipe;
  logic signed [pW_IN:0] l_x, h_x, sum, dif;

  // phase=0 ticks carry a stale low sample, so only phase=1 ticks are captured
  assign cap   = iclk_ena & iena & phase;
  assign trunc = iclk_ena & ~iena & (phase | (idx != '0));

  always_ff @(posedge iclk) begin
    if (irst) begin
      phase <= 1'b0;
      idx   <= '0;
    end else if (iclk_ena) begin
      if (iena) begin
        phase <= ~phase;
        if (phase) idx <= idx + 1'b1;  // power-of-two frame: natural wrap
      end else begin
        phase <= 1'b0;
        idx   <= '0;
      end
    end
  end

  // stage 1
  always_ff @(posedge iclk) begin
    if (irst) begin
      s1       <= '0;
      vld_pipe <= '0;
      err_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], cap};
      err_pipe <= {err_pipe[STAGES-1:1], trunc};
      if (cap) s1 <= '{l: idat_l, h: idat_h, idx: idx};
    end
  end

  assign l_x = $signed({s1.l[pW_IN-1], s1.l});
  assign h_x = $signed({s1.h[pW_IN-1], s1.h});
  assign sum = l_x + h_x;
  assign dif = h_x - l_x;

  // stage 2
  always_ff @(posedge iclk) begin
    if (irst) begin
      oapp <= '0;
      odet <= '0;
      ocnt <= '0;
      osop <= 1'b0;
      oeop <= 1'b0;
    end else begin
      osop <= vld_pipe[1] & (s1.idx == '0);
      oeop <= vld_pipe[1] & (s1.idx == LAST);
      if (vld_pipe[1]) begin
        oapp <= sum;
        odet <= dif;
        ocnt <= s1.idx;
      end
    end
  end

  assign ovalid = vld_pipe[STAGES];
  assign oerr   = err_pipe[STAGES];

endmodule

// File: tb/tb_wvlt_haar_stage.sv
// Directed bench for wvlt_haar_stage (pW_IN=16, pWORDS=8): ramp, extremes,
// back-to-back frames, truncation, mid-frame reset and off-tick noise.
module tb_wvlt_haar_stage;

  logic               iclk = 1'b0;
  logic               irst, iclk_ena, iena;
  logic signed [15:0] idat_l, idat_h;
  logic               ovalid, osop, oeop, oerr;
  logic signed [16:0] oapp, odet;
  logic [1:0]         ocnt;

  int    total = 0;
  int    bad   = 0;
  bit    noise = 0;
  string cur   = "reset";

  wvlt_haar_stage #(.pW_IN(16), .pWORDS(8)) dut (
    .iclk(iclk), .irst(irst), .iclk_ena(iclk_ena), .iena(iena),
    .idat_l(idat_l), .idat_h(idat_h), .ovalid(ovalid), .oapp(oapp),
    .odet(odet), .ocnt(ocnt), .osop(osop), .oeop(oeop), .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s/%s got=%0d exp=%0d", cur, tag, act, exp);
    end
  endtask

  task automatic scramble();
    if (noise) begin
      iena   = 1'($urandom);
      idat_l = 16'($urandom);
      idat_h = 16'($urandom);
    end
  endtask

  task automatic step();
    @(posedge iclk); #1;
    scramble();
  endtask

  // One tick, then checks at tick+1 (idle), tick+2 (result), tick+3 (pulse gone); spacing 4
  task automatic do_tick(input logic en, input int l, input int h, input logic ev,
                         input int eapp, input int edet, input int ecnt,
                         input logic esop, input logic eeop, input logic eerr);
    iclk_ena = 1'b1; iena = en; idat_l = 16'(l); idat_h = 16'(h);
    @(posedge iclk); #1;
    iclk_ena = 1'b0;
    scramble();
    chk("v_t1", int'(ovalid), 0);
    step();
    chk("valid", int'(ovalid), int'(ev));
    chk("sop", int'(osop), int'(esop));
    chk("eop", int'(oeop), int'(eeop));
    chk("err", int'(oerr), int'(eerr));
    if (ev) begin
      chk("app", int'(oapp), eapp);
      chk("det", int'(odet), edet);
      chk("cnt", int'(ocnt), ecnt);
    end
    step();
    chk("v_t3", int'(ovalid), 0);
    chk("err_t3", int'(oerr), 0);
    step();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_v"}, int'(ovalid), 0);
    chk({tag, "_app"}, int'(oapp), 0);
    chk({tag, "_det"}, int'(odet), 0);
    chk({tag, "_cnt"}, int'(ocnt), 0);
    chk({tag, "_sop"}, int'(osop), 0);
    chk({tag, "_eop"}, int'(oeop), 0);
    chk({tag, "_err"}, int'(oerr), 0);
  endtask

  task automatic run_ramp();
    int ramp_app[4] = '{1, 5, 9, 13};
    for (int n = 0; n < 8; n++)
      do_tick(1'b1, (n == 0) ? 0 : n - 1, n, 1'(n % 2), ramp_app[n/2], 1, n/2,
              (n/2 == 0) && (n % 2 == 1), (n/2 == 3) && (n % 2 == 1), 1'b0);
  endtask

  initial begin
    irst = 1'b1; iclk_ena = 1'b0; iena = 1'b0; idat_l = '0; idat_h = '0;
    repeat (3) @(posedge iclk);
    #1;
    check_zero("rst");
    irst = 1'b0;

    cur = "ramp";
    run_ramp();

    cur = "idle";
    do_tick(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    cur = "extremes";
    do_tick(1'b1, 0, -32768, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    do_tick(1'b1, -32768, -32768, 1'b1, -65536, 0, 0, 1'b1, 1'b0, 1'b0);
    do_tick(1'b1, 5, -32768, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    do_tick(1'b1, -32768, 32767, 1'b1, -1, 65535, 1, 1'b0, 1'b0, 1'b0);
    do_tick(1'b1, 7, 32767, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    do_tick(1'b1, 32767, -32768, 1'b1, -1, -65535, 2, 1'b0, 1'b0, 1'b0);
    do_tick(1'b1, 9, 100, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    do_tick(1'b1, 100, -7, 1'b1, 93, -107, 3, 1'b0, 1'b1, 1'b0);

    cur = "b2b";
    for (int n = 0; n < 16; n++)
      do_tick(1'b1, (n == 0) ? 0 : 3*(n-1), 3*n, 1'(n % 2), 6*n - 3, 3, (n/2) % 4,
              ((n/2) % 4 == 0) && (n % 2 == 1), ((n/2) % 4 == 3) && (n % 2 == 1), 1'b0);

    cur = "trunc";
    do_tick(1'b1, 0, 10, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    do_tick(1'b1, 10, 20, 1'b1, 30, 10, 0, 1'b1, 1'b0, 1'b0);
    do_tick(1'b1, 20, 30, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    do_tick(1'b1, 30, 45, 1'b1, 75, 15, 1, 1'b0, 1'b0, 1'b0);
    do_tick(1'b1, 45, 50, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    do_tick(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    do_tick(1'b1, 0, -4, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    do_tick(1'b1, -4, 6, 1'b1, 2, 10, 0, 1'b1, 1'b0, 1'b0);

    cur = "midrst";
    do_tick(1'b1, 6, 8, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    iclk_ena = 1'b1; iena = 1'b1; idat_l = 16'sd8; idat_h = 16'sd11;
    @(posedge iclk); #1;
    iclk_ena = 1'b0; irst = 1'b1;
    @(posedge iclk); #1;
    irst = 1'b0;
    check_zero("t2");
    @(posedge iclk); #1;
    chk("t3_v", int'(ovalid), 0);
    @(posedge iclk); #1;
    do_tick(1'b1, 0, 1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    do_tick(1'b1, 1, 2, 1'b1, 3, 1, 0, 1'b1, 1'b0, 1'b0);
    do_tick(1'b1, 2, 3, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    do_tick(1'b1, 3, 4, 1'b1, 7, 1, 1, 1'b0, 1'b0, 1'b0);

    // reset back to a frame boundary, then repeat the ramp with off-tick noise
    irst = 1'b1;
    @(posedge iclk); #1;
    irst = 1'b0;
    cur = "noise";
    noise = 1;
    run_ramp();
    noise = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
